// File: rtl/if_stage_pkg.sv
// Shared constants and stall codes for the instruction-fetch stage of the RV64 core.
package if_stage_pkg;

   localparam int          DEF_XLEN     = 64;
   localparam logic [63:0] DEF_PC_RESET = 64'h0000_0000_8000_0000;
   localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      STALL_NEXT = 2'd0,
      STALL_KEEP = 2'd1,
      STALL_ZERO = 2'd2
   } stall_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory handshake: one request channel plus a response channel.
interface if_stage_if
   import if_stage_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) ();

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: loads, flushes to a bubble, or holds according to its stall code.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int          XLEN     = DEF_XLEN,
   parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      stall_i,
   input  logic            valid_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     inst_i,
   input  logic            misalign_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [31:0]     inst_o,
   output logic            misalign_o
);

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     inst_q;
   logic            misalign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         inst_q     <= NOP_INST;
         misalign_q <= 1'b0;
      end else begin
         case (stall_i)
            STALL_NEXT: begin
               valid_q    <= valid_i;
               pc_q       <= pc_i;
               inst_q     <= inst_i;
               misalign_q <= misalign_i;
            end
            STALL_ZERO: begin
               valid_q    <= 1'b0;
               pc_q       <= '0;
               inst_q     <= NOP_INST;
               misalign_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign valid_o    = valid_q;
   assign pc_o       = pc_q;
   assign inst_o     = inst_q;
   assign misalign_o = misalign_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM, redirect latch and IF/ID register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter logic [XLEN-1:0] PC_RESET = XLEN'(DEF_PC_RESET),
   parameter logic [31:0]     NOP_INST = DEF_NOP_INST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      pc_stall,
   input  logic [1:0]      if_id_stall,
   input  logic            exc_redirect,
   input  logic [XLEN-1:0] exc_target,
   input  logic            br_redirect,
   input  logic [XLEN-1:0] br_target,
   output logic            if_stall_req,
   if_stage_if.master      imem,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_inst,
   output logic            id_misalign
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DROP} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, redir_pc_q, redir_pc_d, req_addr_q, req_addr_d;
   logic            redir_pend_q, redir_pend_d, redir_exc_q, redir_exc_d;
   logic [31:0]     inst_buf_q, inst_buf_d;
   logic            misalign_buf_q, misalign_buf_d;
   logic            drop_need_ready_q, drop_need_ready_d;
   logic            req_valid_q, req_valid_d, stall_req_q, stall_req_d;
   logic            pc_advance, kill, pc_aligned, fetch_done;

   // Illegal NEXT codes degrade to KEEP; an exception may advance the PC from any state.
   assign pc_advance = (pc_stall == STALL_NEXT) && ((state_q == S_DONE) || exc_redirect);
   assign kill       = pc_advance && exc_redirect;
   assign pc_aligned = (pc_q[1:0] == 2'b00);
   assign fetch_done = (state_q == S_DONE);

   always_comb begin
      pc_d         = pc_q;
      redir_pend_d = redir_pend_q;
      redir_exc_d  = redir_exc_q;
      redir_pc_d   = redir_pc_q;
      if (pc_advance) begin
         if (exc_redirect)      pc_d = exc_target;
         else if (br_redirect)  pc_d = br_target;
         else if (redir_pend_q) pc_d = redir_pc_q;
         else                   pc_d = pc_q + XLEN'(4);
         redir_pend_d = 1'b0;
         redir_exc_d  = 1'b0;
      end else if (exc_redirect) begin
         redir_pend_d = 1'b1;
         redir_exc_d  = 1'b1;
         redir_pc_d   = exc_target;
      end else if (br_redirect && !redir_exc_q) begin
         redir_pend_d = 1'b1;
         redir_pc_d   = br_target;
      end
   end

   // A killed transaction still runs to completion in DROP so its response never lands in a later WAIT.
   always_comb begin
      state_d           = state_q;
      inst_buf_d        = inst_buf_q;
      misalign_buf_d    = misalign_buf_q;
      drop_need_ready_d = drop_need_ready_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (!pc_aligned) begin
               if (kill) begin
                  state_d = S_REQ;
               end else begin
                  inst_buf_d     = NOP_INST;
                  misalign_buf_d = 1'b1;
                  state_d        = S_DONE;
               end
            end else if (imem.imem_req_ready) begin
               state_d           = kill ? S_DROP : S_WAIT;
               drop_need_ready_d = 1'b0;
            end else if (kill) begin
               state_d           = S_DROP;
               drop_need_ready_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem.imem_resp_valid) begin
               if (kill) begin
                  state_d = S_REQ;
               end else begin
                  inst_buf_d     = imem.imem_resp_data;
                  misalign_buf_d = 1'b0;
                  state_d        = S_DONE;
               end
            end else if (kill) begin
               state_d           = S_DROP;
               drop_need_ready_d = 1'b0;
            end
         end
         S_DONE: if (pc_advance) state_d = S_REQ;
         S_DROP: begin
            if (drop_need_ready_q) begin
               if (imem.imem_req_ready) drop_need_ready_d = 1'b0;
            end else if (imem.imem_resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      req_valid_d = ((state_d == S_REQ) && (pc_d[1:0] == 2'b00)) ||
                    ((state_d == S_DROP) && drop_need_ready_d);
      stall_req_d = (state_d != S_DONE);
      req_addr_d  = (state_d == S_DROP) ? req_addr_q : pc_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= S_IDLE;
         pc_q              <= PC_RESET;
         redir_pend_q      <= 1'b0;
         redir_exc_q       <= 1'b0;
         redir_pc_q        <= '0;
         inst_buf_q        <= NOP_INST;
         misalign_buf_q    <= 1'b0;
         drop_need_ready_q <= 1'b0;
         req_valid_q       <= 1'b0;
         stall_req_q       <= 1'b1;
         req_addr_q        <= PC_RESET;
      end else begin
         state_q           <= state_d;
         pc_q              <= pc_d;
         redir_pend_q      <= redir_pend_d;
         redir_exc_q       <= redir_exc_d;
         redir_pc_q        <= redir_pc_d;
         inst_buf_q        <= inst_buf_d;
         misalign_buf_q    <= misalign_buf_d;
         drop_need_ready_q <= drop_need_ready_d;
         req_valid_q       <= req_valid_d;
         stall_req_q       <= stall_req_d;
         req_addr_q        <= req_addr_d;
      end
   end

   assign if_stall_req        = stall_req_q;
   assign imem.imem_req_valid = req_valid_q;
   assign imem.imem_req_addr  = req_addr_q;

   if_id_reg #(
      .XLEN     (XLEN),
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (if_id_stall),
      .valid_i    (fetch_done),
      .pc_i       (pc_q),
      .inst_i     (inst_buf_q),
      .misalign_i (misalign_buf_q),
      .valid_o    (id_valid),
      .pc_o       (id_pc),
      .inst_o     (id_inst),
      .misalign_o (id_misalign)
   );

   a_pc_stall_not_zero: assert property (@(posedge clk) disable iff (rst)
      pc_stall != STALL_ZERO);

   a_pc_next_only_when_done: assert property (@(posedge clk) disable iff (rst)
      (pc_stall == STALL_NEXT) |-> ((state_q == S_DONE) || exc_redirect));

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV64 core: PC register, single-outstanding fetch FSM on the instruction-memory handshake, redirect-pending latch, and the IF/ID pipeline register.
- Produces if_stall_req for the hazard unit and consumes its pc_stall / if_id_stall codes.
- Feeds the ID stage.

Parameters:
- XLEN, 64, PC/data width
- PC_RESET, 64'h8000_0000, PC value after reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_stall  in  2  stall code for the PC register (`STALL_NEXT/`STALL_KEEP/`STALL_ZERO)
- if_id_stall  in  2  stall code for the IF/ID register
- exc_redirect  in  1  exception/trap transfer this cycle
- exc_target  in  XLEN  trap target PC
- br_redirect  in  1  taken branch/jump this cycle (already masked by exception)
- br_target  in  XLEN  branch/jump target PC
- if_stall_req  out  1  fetch not complete
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_resp_valid  in  1  response data valid
- imem_resp_data  in  32  fetched instruction
- id_valid  out  1  IF/ID holds a real instruction
- id_pc  out  XLEN  IF/ID PC
- id_inst  out  32  IF/ID instruction
- id_misalign  out  1  IF/ID instruction-address-misaligned flag

Behaviour:
- Clock/reset: one clock clk; rst asynchronous, active-high.
- Reset values: pc=PC_RESET, state=IDLE, redir_pend=0, id_valid=0, id_pc=0, id_inst=NOP_INST, id_misalign=0, imem_req_valid=0, if_stall_req=1.
- FSM states and transitions:
  - IDLE: req_valid=0, stall_req=1; always -> REQ next cycle.
  - REQ: req_valid=1, addr=pc, stall_req=1.
    - pc[1:0]!=0: no request; capture inst=NOP_INST, misalign=1; -> DONE.
    - Else on ready -> WAIT.
    - req_valid and addr stay stable until ready.
  - WAIT: req_valid=0, stall_req=1. On resp_valid: inst_buf=resp_data, misalign=0; -> DONE. A response never arrives in the same cycle as its acceptance.
  - DONE: stall_req=0. If pc_stall==NEXT -> REQ, else stay.
- Latency: at least 3 cycles per instruction with zero-wait memory (REQ, WAIT, DONE).
- PC register:
  - NEXT: pc <= exc_redirect ? exc_target : br_redirect ? br_target : redir_pend ? redir_pc : pc+4. redir_pend cleared.
  - KEEP: hold.
  - ZERO: illegal for the PC; treated as KEEP, flagged by an assertion.
  - NEXT while state!=DONE and no exc_redirect: illegal; treated as KEEP, flagged by an assertion.
  - Exception: NEXT with exc_redirect in any state is legal. It loads exc_target and clears redir_pend. The in-flight transaction completes and its response is discarded: state goes to DROP, which waits for resp_valid (or for ready if still in REQ) and then -> REQ.
  - DROP: stall_req=1, req_valid=1 only if the request was not yet accepted.
- Redirect latch, when a redirect arrives and pc_stall!=NEXT:
  - exc_redirect: redir_pend=1, redir_pc=exc_target; overwrites any pending branch.
  - br_redirect: captured only if no exception is pending.
  - Simultaneous exc and br: exception wins.
- IF/ID register:
  - NEXT: id_valid=(state==DONE), id_pc=pc, id_inst=inst_buf, id_misalign=misalign_buf.
  - ZERO: id_valid=0, id_pc=0, id_inst=NOP_INST, id_misalign=0.
  - KEEP: hold.
- pc+4 wraps modulo 2^XLEN.
- Reset mid-fetch: state returns to IDLE immediately. A late response arriving after reset is ignored because it is not in the WAIT state.

Decomposition:
- Shared defines: STALL_NEXT/STALL_KEEP/STALL_ZERO codes, NOP_INST, PC_RESET, XLEN.
- Fetch FSM state encoding local to if_stage.
- One sub-module: if_id_reg (IF/ID register applying a stall code to {valid, pc, inst, misalign}).

Test Plan:
- Reset release, zero-wait memory, pc_stall=NEXT whenever stall_req=0 -> imem_req_addr 0x80000000, 0x80000004, 0x80000008; id_inst tracks resp_data; if_stall_req low one cycle per fetch.
- br_redirect=1, br_target=0x80001000 while in WAIT (pc_stall=KEEP) -> pending latched; after response and NEXT, next req addr 0x80001000, never 0x80000008.
- exc_redirect(target 0x80000100) and br_redirect(0x80002000) in the same KEEP cycle -> next fetch 0x80000100.
- exc_redirect with pc_stall=NEXT while in WAIT -> late response dropped; next req 0x80000100; id_inst never shows the dropped data.
- br_target=0x80000002 -> no imem request; id_misalign=1, id_inst=0x00000013.
- imem_req_ready held low 5 cycles -> req_valid/addr stable throughout; rst pulsed in WAIT -> all outputs at reset values asynchronously, refetch from 0x80000000.
